// File: rtl/multi_channel_bus_watchdog.sv
// N-channel bus transaction watchdog.
// Each channel times start->complete against a limit latched at transaction
// start, raises a one-cycle timeout pulse plus sticky status on a miss, flags
// overlapping starts, and all channels feed one saturating timeout counter.
module multi_channel_bus_watchdog #(
   parameter int NUM_CH    = 4,
   parameter int CNT_W     = 8,
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_CH-1:0]    start,
   input  logic [NUM_CH-1:0]    complete,
   input  logic [CNT_W-1:0]     timeout_limit,
   input  logic                 retrigger_en,
   input  logic [NUM_CH-1:0]    err_clear,
   input  logic                 count_clear,
   output logic [NUM_CH-1:0]    active,
   output logic [NUM_CH-1:0]    timeout_pulse,
   output logic [NUM_CH-1:0]    timeout_sticky,
   output logic [NUM_CH-1:0]    overlap_err,
   output logic                 any_error,
   output logic [ERR_CNT_W-1:0] timeout_count
);

   // Popcount width and a sum width wide enough to hold count + popcount
   // without overflow, so saturation can be detected by a plain compare.
   localparam int PC_W  = $clog2(NUM_CH + 1);
   localparam int SUM_W = ((ERR_CNT_W > PC_W) ? ERR_CNT_W : PC_W) + 1;
   localparam logic [SUM_W-1:0] COUNT_MAX = {{(SUM_W-ERR_CNT_W){1'b0}}, {ERR_CNT_W{1'b1}}};

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACTIVE  = 2'd1,
      EXPIRED = 2'd2
   } state_t;

   logic [NUM_CH-1:0]    timeout_event;
   logic [SUM_W-1:0]     event_sum;
   logic [SUM_W-1:0]     count_sum;
   logic [ERR_CNT_W-1:0] count_next;
   logic [ERR_CNT_W-1:0] timeout_count_reg;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         state_t           state_reg;
         logic [CNT_W-1:0] cnt_reg;
         logic [CNT_W-1:0] limit_reg;
         logic             active_reg;
         logic             pulse_reg;
         logic             sticky_reg;
         logic             overlap_reg;
         logic             at_limit;
         logic             restart;
         logic             overlap_hit;

         // Last counted cycle of the window; limit 0 disables expiry.
         assign at_limit    = (limit_reg != '0) && (cnt_reg == (limit_reg - CNT_W'(1)));
         // Back-to-back transaction or retrigger: timer restarts in ACTIVE.
         assign restart     = start[gi] && (complete[gi] || retrigger_en);
         // A start without completion while not retriggering is a protocol overlap;
         // the timer keeps running so this can coincide with a timeout.
         assign overlap_hit = (state_reg == ACTIVE) && start[gi] && !complete[gi] && !retrigger_en;
         assign timeout_event[gi] = (state_reg == ACTIVE) && !complete[gi] && !restart && at_limit;

         // Per-channel FSM with registered status outputs.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               state_reg   <= IDLE;
               cnt_reg     <= '0;
               limit_reg   <= '0;
               active_reg  <= 1'b0;
               pulse_reg   <= 1'b0;
               sticky_reg  <= 1'b0;
               overlap_reg <= 1'b0;
            end else begin
               pulse_reg <= 1'b0;
               case (state_reg)
                  IDLE: begin
                     if (start[gi]) begin
                        state_reg  <= ACTIVE;
                        cnt_reg    <= '0;
                        limit_reg  <= timeout_limit;
                        active_reg <= 1'b1;
                     end
                  end
                  ACTIVE: begin
                     if (restart) begin
                        cnt_reg   <= '0;
                        limit_reg <= timeout_limit;
                     end else if (complete[gi]) begin
                        state_reg  <= IDLE;
                        active_reg <= 1'b0;
                     end else if (at_limit) begin
                        state_reg  <= EXPIRED;
                        active_reg <= 1'b0;
                        pulse_reg  <= 1'b1;
                     end else if (limit_reg != '0) begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                     end
                  end
                  EXPIRED: begin
                     if (start[gi]) begin
                        state_reg  <= ACTIVE;
                        cnt_reg    <= '0;
                        limit_reg  <= timeout_limit;
                        active_reg <= 1'b1;
                     end else if (complete[gi]) begin
                        state_reg <= IDLE;
                     end
                  end
                  default: begin
                     state_reg  <= IDLE;
                     active_reg <= 1'b0;
                  end
               endcase

               // Sticky bits: a new event outranks a same-cycle clear.
               if (timeout_event[gi])
                  sticky_reg <= 1'b1;
               else if (err_clear[gi])
                  sticky_reg <= 1'b0;

               if (overlap_hit)
                  overlap_reg <= 1'b1;
               else if (err_clear[gi])
                  overlap_reg <= 1'b0;
            end
         end

         assign active[gi]         = active_reg;
         assign timeout_pulse[gi]  = pulse_reg;
         assign timeout_sticky[gi] = sticky_reg;
         assign overlap_err[gi]    = overlap_reg;
      end
   endgenerate

   // Next value of the saturating global timeout counter.
   always_comb begin
      event_sum = '0;
      for (int i = 0; i < NUM_CH; i++)
         event_sum = event_sum + SUM_W'(timeout_event[i]);
      if (count_clear)
         count_sum = event_sum;
      else
         count_sum = event_sum + {{(SUM_W-ERR_CNT_W){1'b0}}, timeout_count_reg};
      count_next = (count_sum > COUNT_MAX) ? {ERR_CNT_W{1'b1}} : count_sum[ERR_CNT_W-1:0];
   end

   // Global timeout counter register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         timeout_count_reg <= '0;
      else
         timeout_count_reg <= count_next;
   end

   assign timeout_count = timeout_count_reg;
   assign any_error     = |{timeout_sticky, overlap_err};

endmodule
